// File: rtl/hv_search_arbiter.sv
// rtl/hv_search_arbiter.sv - round-robin arbiter sharing one am_search unit between HV encoders
//
// Each requester owns a one-entry HV slot. A done pulse fills the slot, or sets the
// sticky overrun flag if the slot is still occupied and not being granted on that edge.
// A four-state FSM (IDLE -> ISSUE -> WAIT -> RESP) takes one slot at a time.
// The slot is chosen round-robin starting at rr_ptr. The FSM drives the search unit
// and returns the class to the requester that owns the slot.
//
// Optional feature macro: HV_ARB_TIMEOUT_EN
//   When it is defined, WAIT gives up after AM_TIMEOUT cycles without am_done. The block
//   then answers with an all-ones class and pulses timeout.
//   When it is undefined, WAIT lasts until am_done and timeout is tied low.

module hv_search_arbiter #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_REQ    = 2,
  parameter int CLASS_W    = 1,
  parameter int AM_TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [NUM_REQ-1:0]              req_done,
  input  logic [NUM_REQ*DIMENSIONS-1:0]   req_hv,
  output logic                            am_start,
  output logic [DIMENSIONS-1:0]           am_hv,
  input  logic                            am_done,
  input  logic [CLASS_W-1:0]              am_class,
  output logic [NUM_REQ-1:0]              res_valid,
  output logic [CLASS_W-1:0]              res_class,
  output logic                            busy,
  output logic [NUM_REQ-1:0]              overrun,
  output logic                            timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // A single requester would not need an arbiter, and a zero timeout would abort every search.
  if (NUM_REQ < 2 || AM_TIMEOUT < 1) begin : g_param_check
    $error("hv_search_arbiter: NUM_REQ must be >= 2 and AM_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant;
  logic [PTR_W-1:0]       pick;
  logic [PTR_W-1:0]       cand;
  logic                   pick_found;
  int                     rr_idx;

  logic [NUM_REQ-1:0]     pend;
  logic [NUM_REQ-1:0]     grant_now;
  logic [DIMENSIONS-1:0]  slot_hv [NUM_REQ];

  // Qualified events out of WAIT: a real result or a timeout abort.
  logic                   am_hit;
  logic                   abort;
  logic                   to_hit;

  assign busy = (state != ST_IDLE);

  // Round-robin pick: the first pending slot at or above rr_ptr, wrapping past the top.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    rr_idx     = 0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NUM_REQ) begin
        rr_idx = rr_idx - NUM_REQ;
      end
      cand = PTR_W'(rr_idx);
      if (!pick_found && pend[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  // FSM next-state logic and the per-edge strobes derived from it.
  always_comb begin
    state_nxt = state;
    grant_now = '0;
    am_hit    = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_now[pick] = 1'b1;
          state_nxt       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (am_done) begin
          am_hit    = 1'b1;
          state_nxt = ST_RESP;
        end else if (to_hit) begin
          abort     = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Slot capture: an empty slot, or a slot emptied by a grant on this edge, takes the new HV.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_hv[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_done[i]) begin
          if (!pend[i] || grant_now[i]) begin
            slot_hv[i] <= req_hv[i*DIMENSIONS +: DIMENSIONS];
            pend[i]    <= 1'b1;
          end else begin
            overrun[i] <= 1'b1;
          end
        end else if (grant_now[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Grant bookkeeping: latch the winner and its query HV, then advance the pointer past it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant  <= '0;
      rr_ptr <= '0;
      am_hv  <= '0;
    end else begin
      if (state == ST_IDLE && pick_found) begin
        grant <= pick;
        am_hv <= slot_hv[pick];
      end
      if (state == ST_RESP) begin
        rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Search handshake and result return. res_valid is a one-cycle pulse that RESP clears.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      am_start  <= 1'b0;
      res_valid <= '0;
      res_class <= '0;
    end else begin
      am_start  <= (state == ST_ISSUE);
      res_valid <= '0;
      if (am_hit) begin
        res_valid[grant] <= 1'b1;
        res_class        <= am_class;
      end else if (abort) begin
        res_valid[grant] <= 1'b1;
        res_class        <= '1;
      end
    end
  end

`ifdef HV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(AM_TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             timeout_q;

  assign to_hit  = (to_cnt == CNT_W'(AM_TIMEOUT - 1));
  assign timeout = timeout_q;

  // WAIT-cycle counter: cleared while entering WAIT, counts every WAIT edge without am_done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      to_cnt <= '0;
    end else if (state == ST_WAIT && !am_done) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // One-cycle abort flag that accompanies the all-ones result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hv_search_arbiter.sv
// tb/tb_hv_search_arbiter.sv - directed scoreboard bench for hv_search_arbiter

module tb_hv_search_arbiter;

  localparam int D  = 64;
  localparam int NR = 2;
  localparam int CW = 2;
  localparam int TO = 16;

  logic             clk;
  logic             nrst;
  logic [NR-1:0]    req_done;
  logic [NR*D-1:0]  req_hv;
  logic             am_start;
  logic [D-1:0]     am_hv;
  logic             am_done;
  logic [CW-1:0]    am_class;
  logic [NR-1:0]    res_valid;
  logic [CW-1:0]    res_class;
  logic             busy;
  logic [NR-1:0]    overrun;
  logic             timeout;

  typedef struct {
    int          slot;
    logic [63:0] hv;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  hv_search_arbiter #(
    .DIMENSIONS (D),
    .NUM_REQ    (NR),
    .CLASS_W    (CW),
    .AM_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_done  (req_done),
    .req_hv    (req_hv),
    .am_start  (am_start),
    .am_hv     (am_hv),
    .am_done   (am_done),
    .am_class  (am_class),
    .res_valid (res_valid),
    .res_class (res_class),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NR-1:0] mask, input logic [63:0] h0, input logic [63:0] h1);
    req_done = mask;
    req_hv   = {h1, h0};
    tick();
    req_done = '0;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (am_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_am_start"}, 64'(am_start), 64'(1));
  endtask

  task automatic serve(input string tag, input int lat, input logic [CW-1:0] cls);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_am_hv"}, 64'(am_hv), e.hv);
    repeat (lat) tick();
    am_done  = 1'b1;
    am_class = cls;
    tick();
    am_done  = 1'b0;
    am_class = '0;
    chk({tag, "_start_pulse"}, 64'(am_start), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(1) << e.slot);
    chk({tag, "_res_class"}, 64'(res_class), 64'(cls));
    tick();
    chk({tag, "_res_valid_end"}, 64'(res_valid), 64'(0));
  endtask

  initial begin
    int n;
    nrst     = 1'b0;
    req_done = '0;
    req_hv   = '0;
    am_done  = 1'b0;
    am_class = '0;
    tick();

    chk("rst_am_start", 64'(am_start), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_am_hv", 64'(am_hv), 64'(0));
    nrst = 1'b1;
    tick();

    // Reset while the search unit is working.
    pulse(2'b01, 64'h1111_2222_3333_4444, 64'h0);
    wait_start("t1", n);
    tick();
    chk("t1_busy_wait", 64'(busy), 64'(1));
    nrst = 1'b0;
    #1;
    chk("t1_async_busy", 64'(busy), 64'(0));
    tick();
    chk("t1_am_start", 64'(am_start), 64'(0));
    chk("t1_res_valid", 64'(res_valid), 64'(0));
    chk("t1_overrun", 64'(overrun), 64'(0));
    nrst = 1'b1;
    am_done = 1'b1;
    tick();
    am_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t1_no_res", 64'(res_valid), 64'(0));
      chk("t1_idle", 64'(busy), 64'(0));
      tick();
    end

    // Single request; also checks the grant/start latency.
    pulse(2'b01, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0);
    sb.push_back('{0, 64'hA5A5_A5A5_A5A5_A5A5});
    wait_start("t2", n);
    chk("t2_latency", 64'(n), 64'(2));
    serve("t2", 5, 2'd1);

    // Simultaneous requests; slot 0 goes first after reset, twice in a row.
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      pulse(2'b11, 64'h0123_4567_89AB_CDEF + 64'(p), 64'hFEDC_BA98_7654_3210 + 64'(p));
      sb.push_back('{0, 64'h0123_4567_89AB_CDEF + 64'(p)});
      sb.push_back('{1, 64'hFEDC_BA98_7654_3210 + 64'(p)});
      wait_start("t3a", n);
      serve("t3a", p, 2'd2);
      wait_start("t3b", n);
      serve("t3b", 3, 2'd3);
    end

    // Overrun on slot 1 while slot 0 is in WAIT.
    pulse(2'b01, 64'hAAAA_0000_0000_0001, 64'h0);
    sb.push_back('{0, 64'hAAAA_0000_0000_0001});
    wait_start("t4a", n);
    pulse(2'b10, 64'h0, 64'hBBBB_0000_0000_0002);
    sb.push_back('{1, 64'hBBBB_0000_0000_0002});
    chk("t4_overrun_first", 64'(overrun), 64'(0));
    pulse(2'b10, 64'h0, 64'hCCCC_0000_0000_0003);
    chk("t4_overrun_set", 64'(overrun), 64'(2'b10));
    serve("t4a", 2, 2'd1);
    wait_start("t4b", n);
    serve("t4b", 1, 2'd0);
    repeat (4) tick();
    chk("t4_drained", 64'(busy), 64'(0));
    chk("t4_overrun_sticky", 64'(overrun), 64'(2'b10));

    // A new done on the very edge that grants the slot.
    apply_reset();
    pulse(2'b01, 64'hDDDD_0000_0000_0004, 64'h0);
    sb.push_back('{0, 64'hDDDD_0000_0000_0004});
    pulse(2'b01, 64'hEEEE_0000_0000_0005, 64'h0);
    sb.push_back('{0, 64'hEEEE_0000_0000_0005});
    wait_start("t5a", n);
    chk("t5_latency", 64'(n), 64'(1));
    serve("t5a", 2, 2'd3);
    wait_start("t5b", n);
    serve("t5b", 2, 2'd2);
    chk("t5_overrun", 64'(overrun), 64'(0));

    // The search unit never answers.
    pulse(2'b10, 64'h0, 64'h5555_0000_0000_0006);
    sb.push_back('{1, 64'h5555_0000_0000_0006});
    wait_start("t6", n);
`ifdef HV_ARB_TIMEOUT_EN
    begin
      exp_t e;
      e = sb.pop_front();
      chk("t6_am_hv", 64'(am_hv), e.hv);
      repeat (TO - 1) tick();
      chk("t6_no_timeout_yet", 64'(timeout), 64'(0));
      chk("t6_no_res_yet", 64'(res_valid), 64'(0));
      tick();
      chk("t6_timeout", 64'(timeout), 64'(1));
      chk("t6_res_valid", 64'(res_valid), 64'(1) << e.slot);
      chk("t6_res_class", 64'(res_class), 64'(2'b11));
      tick();
      chk("t6_timeout_end", 64'(timeout), 64'(0));
      chk("t6_res_end", 64'(res_valid), 64'(0));
      am_done  = 1'b1;
      am_class = 2'd1;
      tick();
      am_done  = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("t6_late_ignored", 64'(res_valid), 64'(0));
        chk("t6_late_idle", 64'(busy), 64'(0));
        tick();
      end
    end
`else
    for (int i = 0; i < 3 * TO; i++) begin
      chk("t6_busy_hold", 64'(busy), 64'(1));
      chk("t6_timeout_low", 64'(timeout), 64'(0));
      tick();
    end
    serve("t6", 0, 2'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
